pretrig_capture_buffer: RTL and testbench

- Single-clock, multi-channel sample capture buffer with programmable pre-trigger and post-trigger depth.
- While armed, samples are continuously written into a circular RAM. A trigger freezes the last N pre-trigger samples and captures a fixed number of post-trigger samples.
- Readout is then streamed oldest-first.
- Sits between the ADC sample front end and the host readout logic. It is the successor to the dual-clock circular/main variable-width FIFO, adding an explicit arm/trigger/done FSM, clamping, channel packing and unwound readout.

---
 rtl/pretrig_capture_buffer_pkg.sv | 23 ++
 rtl/pretrig_capture_buffer_if.sv | 33 +++
 rtl/pretrig_capture_buffer_sdp_ram.sv | 20 ++
 rtl/pretrig_capture_buffer.sv | 120 ++++++++++++
 tb/tb_pretrig_capture_buffer.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/pretrig_capture_buffer_pkg.sv
// Shared types and helpers for the pre-trigger capture buffer.
package pretrig_capture_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int clamp_cnt(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

endpackage

// File: rtl/pretrig_capture_buffer_if.sv
// Sample-in / config / readout bundle between front end, host and capture buffer.
interface pretrig_capture_buffer_if #(
  parameter int data_width   = 10,
  parameter int num_channels = 1,
  parameter int depth_log2   = 11
);
  localparam int cnt_width = depth_log2 + 1;
  localparam int word_width = data_width * num_channels;

  logic                  arm;
  logic [cnt_width-1:0]  pre_samples;
  logic [cnt_width-1:0]  total_samples;
  logic [word_width-1:0] wr_data;
  logic                  wr_ce;
  logic                  trigger;
  logic [1:0]            state;
  logic                  done;
  logic [cnt_width-1:0]  pre_valid;
  logic                  rd_en;
  logic [word_width-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_last;

  modport master (
    output arm, pre_samples, total_samples, wr_data, wr_ce, trigger, rd_en,
    input  state, done, pre_valid, rd_data, rd_valid, rd_last
  );

  modport slave (
    input  arm, pre_samples, total_samples, wr_data, wr_ce, trigger, rd_en,
    output state, done, pre_valid, rd_data, rd_valid, rd_last
  );
endinterface

// File: rtl/pretrig_capture_buffer_sdp_ram.sv
// Single-clock simple dual-port RAM with a registered read port (block-RAM style).
module capture_sdp_ram #(
  parameter int width      = 10,
  parameter int addr_width = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [width-1:0]      wdata,
  input  logic                  re,
  input  logic [addr_width-1:0] raddr,
  output logic [width-1:0]      rdata
);
  logic [width-1:0] mem [2**addr_width];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/pretrig_capture_buffer.sv
// Circular pre-trigger capture with arm/trigger/done FSM and oldest-first readout.
module pretrig_capture_buffer
  import pretrig_capture_buffer_pkg::*;
#(
  parameter int data_width   = 10,
  parameter int num_channels = 1,
  parameter int depth_log2   = 11
) (
  input logic clk,
  input logic rst_n,
  pretrig_capture_buffer_if.slave bus
);
  localparam int DEPTH = 1 << depth_log2;
  localparam int AW    = depth_log2;
  localparam int CW    = depth_log2 + 1;
  localparam int W     = data_width * num_channels;

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr, start_addr, start_nxt;
  logic [CW-1:0] fill, pre_lat, post_len, post_cnt, pre_valid, rd_rem;
  logic [CW-1:0] total_cfg, pre_cfg;
  logic          wr_fire, trig_fire, rd_fire, enter_done;
  logic          rd_valid, rd_last;
  logic [W-1:0]  ram_q;

  assign total_cfg  = CW'(clamp_cnt(int'(bus.total_samples), 1, DEPTH));
  assign pre_cfg    = CW'(clamp_cnt(int'(bus.pre_samples), 0, int'(total_cfg) - 1));
  // fill never exceeds DEPTH-1, so the low bits carry the whole value
  assign start_nxt  = wr_ptr - fill[AW-1:0];
  assign enter_done = (state_nxt == ST_DONE) && (state != ST_DONE);

  always_comb begin
    state_nxt = state;
    wr_fire   = 1'b0;
    trig_fire = 1'b0;
    rd_fire   = 1'b0;
    if (bus.arm) state_nxt = ST_PRE;
    else begin
      case (state)
        ST_PRE: if (bus.wr_ce) begin
          wr_fire = 1'b1;
          if (bus.trigger) begin
            trig_fire = 1'b1;
            state_nxt = (post_len == CW'(1)) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: if (bus.wr_ce) begin
          wr_fire = 1'b1;
          if (post_cnt + CW'(1) == post_len) state_nxt = ST_DONE;
        end
        ST_DONE: rd_fire = bus.rd_en && (rd_rem != '0);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      start_addr <= '0;
      fill       <= '0;
      pre_lat    <= '0;
      post_len   <= '0;
      post_cnt   <= '0;
      pre_valid  <= '0;
      rd_rem     <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      rd_last  <= rd_fire && (rd_rem == CW'(1));
      if (bus.arm) begin
        pre_lat  <= pre_cfg;
        post_len <= total_cfg - pre_cfg;
        wr_ptr   <= '0;
        fill     <= '0;
      end
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (wr_fire && !trig_fire && state == ST_PRE)
        fill <= (fill < pre_lat) ? fill + CW'(1) : pre_lat;
      if (trig_fire) begin
        start_addr <= start_nxt;
        pre_valid  <= fill;
        post_cnt   <= CW'(1);
      end else if (wr_fire && state == ST_POST) begin
        post_cnt <= post_cnt + CW'(1);
      end
      if (enter_done) begin
        rd_ptr <= trig_fire ? start_nxt : start_addr;
        rd_rem <= (trig_fire ? fill : pre_valid) + post_len;
      end else if (rd_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
        rd_rem <= rd_rem - CW'(1);
      end
    end
  end

  capture_sdp_ram #(.width(W), .addr_width(AW)) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .re    (rd_fire),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  assign bus.state     = state;
  assign bus.done      = (state == ST_DONE);
  assign bus.pre_valid = pre_valid;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_last   = rd_last;
  assign bus.rd_data   = rd_valid ? ram_q : '0;
endmodule

// File: tb/tb_pretrig_capture_buffer.sv
// Directed bench: table of capture configs plus hand sequences for gaps, abort and reset.
module tb_pretrig_capture_buffer;
  localparam int DW = 10, NC = 3, DL = 4;
  localparam int CW = DL + 1, W = DW * NC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pretrig_capture_buffer_if #(.data_width(DW), .num_channels(NC), .depth_log2(DL)) bus ();

  pretrig_capture_buffer #(.data_width(DW), .num_channels(NC), .depth_log2(DL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int pre; int total; int trig; int exp_pv; int exp_first; int exp_cnt;
  } vec_t;

  vec_t vecs[6];
  int checks = 0;
  int errors = 0;

  function automatic logic [W-1:0] pack(input int v);
    return {10'(v + 512), 10'(v + 256), 10'(v)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_arm(input int pre, input int total);
    bus.arm = 1'b1;
    bus.pre_samples = CW'(pre);
    bus.total_samples = CW'(total);
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic push(input int v, input bit trg);
    bus.wr_data = pack(v);
    bus.wr_ce = 1'b1;
    bus.trigger = trg;
    tick();
    bus.wr_ce = 1'b0;
    bus.trigger = 1'b0;
  endtask

  // Streams base+0, base+1, ... with trigger on index trig until DONE.
  task automatic capture(input int base, input int trig, output int last);
    last = -1;
    for (int v = 0; v < 100; v++) begin
      push(base + v, v == trig);
      if (bus.state == 2'd3) begin
        last = base + v;
        break;
      end
    end
  endtask

  task automatic read_all(input int first, input int cnt);
    for (int i = 0; i <= cnt; i++) begin
      bus.rd_en = 1'b1;
      tick();
      if (i < cnt) begin
        chk("rd_valid", 64'(bus.rd_valid), 64'(1));
        chk("rd_data", 64'(bus.rd_data), 64'(pack(first + i)));
        chk("rd_last", 64'(bus.rd_last), 64'(i == cnt - 1));
      end else begin
        chk("rd_valid_after_last", 64'(bus.rd_valid), 64'(0));
      end
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_state", 64'(bus.state), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_pre_valid", 64'(bus.pre_valid), 64'(0));
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
    chk("rst_rd_last", 64'(bus.rd_last), 64'(0));
    chk("rst_rd_data", 64'(bus.rd_data), 64'(0));
  endtask

  initial begin
    int last;
    int k;
    bit pat[5];
    vecs[0] = '{pre: 4,  total: 8,  trig: 10, exp_pv: 4,  exp_first: 6,  exp_cnt: 8};
    vecs[1] = '{pre: 6,  total: 10, trig: 1,  exp_pv: 1,  exp_first: 0,  exp_cnt: 5};
    vecs[2] = '{pre: 31, total: 31, trig: 50, exp_pv: 15, exp_first: 35, exp_cnt: 16};
    vecs[3] = '{pre: 5,  total: 1,  trig: 3,  exp_pv: 0,  exp_first: 3,  exp_cnt: 1};
    vecs[4] = '{pre: 0,  total: 0,  trig: 0,  exp_pv: 0,  exp_first: 0,  exp_cnt: 1};
    vecs[5] = '{pre: 0,  total: 16, trig: 2,  exp_pv: 0,  exp_first: 2,  exp_cnt: 16};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    bus.arm = 1'b0; bus.pre_samples = '0; bus.total_samples = '0;
    bus.wr_data = '0; bus.wr_ce = 1'b0; bus.trigger = 1'b0; bus.rd_en = 1'b0;
    tick(); tick();
    chk_reset_outputs();
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 64'(bus.state), 64'(0));

    foreach (vecs[i]) begin
      do_arm(vecs[i].pre, vecs[i].total);
      chk("arm_state_pre", 64'(bus.state), 64'(1));
      capture(0, vecs[i].trig, last);
      chk("done_at_sample", 64'(last), 64'(vecs[i].exp_first + vecs[i].exp_cnt - 1));
      chk("done", 64'(bus.done), 64'(1));
      chk("pre_valid", 64'(bus.pre_valid), 64'(vecs[i].exp_pv));
      read_all(vecs[i].exp_first, vecs[i].exp_cnt);
    end

    // rd_valid tracks rd_en one cycle later, with gaps
    do_arm(4, 8);
    capture(0, 10, last);
    k = 0;
    for (int i = 0; i < 5; i++) begin
      bus.rd_en = pat[i];
      tick();
      chk("gap_rd_valid", 64'(bus.rd_valid), 64'(pat[i]));
      if (pat[i]) begin
        chk("gap_rd_data", 64'(bus.rd_data), 64'(pack(6 + k)));
        k++;
      end
    end
    // arm mid-readout drops the read issued on the arm cycle
    bus.rd_en = 1'b1;
    do_arm(4, 8);
    chk("arm_drops_read", 64'(bus.rd_valid), 64'(0));
    chk("arm_from_done", 64'(bus.state), 64'(1));
    tick();
    chk("rd_en_in_pre", 64'(bus.rd_valid), 64'(0));
    bus.rd_en = 1'b0;

    // abort mid-POST with wr_ce and trigger on the arm cycle
    do_arm(4, 8);
    for (int v = 0; v < 7; v++) push(v, v == 5);
    chk("abort_in_post", 64'(bus.state), 64'(2));
    chk("abort_pv_before", 64'(bus.pre_valid), 64'(4));
    bus.wr_ce = 1'b1; bus.trigger = 1'b1; bus.wr_data = pack(99);
    do_arm(2, 4);
    bus.wr_ce = 1'b0; bus.trigger = 1'b0;
    chk("abort_state", 64'(bus.state), 64'(1));
    chk("abort_pv_hold", 64'(bus.pre_valid), 64'(4));
    capture(100, 3, last);
    chk("abort_done_at", 64'(last), 64'(104));
    chk("abort_pv_new", 64'(bus.pre_valid), 64'(2));
    read_all(101, 4);

    // reset mid-POST
    do_arm(4, 8);
    for (int v = 0; v < 7; v++) push(v, v == 5);
    chk("pre_reset_post", 64'(bus.state), 64'(2));
    rst_n = 1'b0;
    tick();
    chk_reset_outputs();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
